// File: rtl/metro_gate_ctrl.sv
// Single-lane metro gate controller: validates an access code against a range,
// opens the door with early close on passage, and tracks rejects, lockout and tailgating.
module metro_gate_ctrl #(
    parameter int CODE_W      = 4,
    parameter int CODE_MIN    = 4,
    parameter int CODE_MAX    = 11,
    parameter int OPEN_CYCLES = 16,
    parameter int DENY_CYCLES = 4,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 32,
    parameter int CNT_W       = 16,
    localparam int FAIL_W     = $clog2(MAX_FAILS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] access_code,
    input  logic              validate_code,
    input  logic              pass_sensor,
    output logic              open_access_door,
    output logic              deny_led,
    output logic              lockout,
    output logic              tailgate_alarm,
    output logic [1:0]        state_out,
    output logic [FAIL_W-1:0] fail_count,
    output logic [CNT_W-1:0]  pass_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_GRANTED = 2'b01,
        S_DENIED  = 2'b10,
        S_LOCKOUT = 2'b11
    } state_t;

    localparam int MAX_OD  = (OPEN_CYCLES > DENY_CYCLES) ? OPEN_CYCLES : DENY_CYCLES;
    localparam int MAX_CYC = (MAX_OD > LOCK_CYCLES) ? MAX_OD : LOCK_CYCLES;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // Timer holds "cycles remaining after this one", so each state loads N-1.
    localparam logic [TMR_W-1:0]  OPEN_LD  = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0]  DENY_LD  = TMR_W'(DENY_CYCLES - 1);
    localparam logic [TMR_W-1:0]  LOCK_LD  = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [CODE_W-1:0] CODE_LO  = CODE_W'(CODE_MIN);
    localparam logic [CODE_W-1:0] CODE_HI  = CODE_W'(CODE_MAX);
    localparam logic [FAIL_W-1:0] FAIL_LIM = FAIL_W'(MAX_FAILS);

    generate
        if (CODE_MIN < 0 || CODE_MIN > CODE_MAX || CODE_MAX >= (1 << CODE_W)) begin : g_bad_code
            $error("metro_gate_ctrl: code range must satisfy 0 <= CODE_MIN <= CODE_MAX < 2**CODE_W");
        end
        if (OPEN_CYCLES < 1 || DENY_CYCLES < 1 || LOCK_CYCLES < 1 || MAX_FAILS < 1) begin : g_bad_cycles
            $error("metro_gate_ctrl: cycle counts and MAX_FAILS must be at least 1");
        end
    endgenerate

    state_t             r_state;
    logic [TMR_W-1:0]   r_timer;
    logic [FAIL_W-1:0]  r_fail_count;
    logic [CNT_W-1:0]   r_pass_count;
    logic               r_tailgate;

    logic               w_code_ok;
    logic [FAIL_W-1:0]  w_fail_next;
    logic               w_timer_done;

    assign w_code_ok    = (access_code >= CODE_LO) && (access_code <= CODE_HI);
    assign w_fail_next  = r_fail_count + FAIL_W'(1);
    assign w_timer_done = (r_timer == '0);

    // NOTE: state updates use non-blocking assignments so every branch sees the pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_fail_count <= '0;
            r_pass_count <= '0;
            r_tailgate   <= 1'b0;
        end else begin
            r_tailgate <= pass_sensor && (r_state != S_GRANTED);

            case (r_state)
                S_IDLE: begin
                    if (validate_code) begin
                        if (w_code_ok) begin
                            r_state      <= S_GRANTED;
                            r_timer      <= OPEN_LD;
                            r_fail_count <= '0;
                        end else begin
                            r_fail_count <= w_fail_next;
                            if (w_fail_next == FAIL_LIM) begin
                                r_state <= S_LOCKOUT;
                                r_timer <= LOCK_LD;
                            end else begin
                                r_state <= S_DENIED;
                                r_timer <= DENY_LD;
                            end
                        end
                    end
                end

                S_GRANTED: begin
                    // A passage always wins, including on the last open cycle.
                    if (pass_sensor) begin
                        r_state      <= S_IDLE;
                        r_pass_count <= r_pass_count + CNT_W'(1);
                    end else if (w_timer_done) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end

                S_DENIED: begin
                    if (w_timer_done) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end

                S_LOCKOUT: begin
                    if (w_timer_done) begin
                        r_state      <= S_IDLE;
                        r_fail_count <= '0;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign open_access_door = (r_state == S_GRANTED);
    assign deny_led         = (r_state == S_DENIED);
    assign lockout          = (r_state == S_LOCKOUT);
    assign tailgate_alarm   = r_tailgate;
    assign state_out        = r_state;
    assign fail_count       = r_fail_count;
    assign pass_count       = r_pass_count;

endmodule

// File: tb/tb_metro_gate_ctrl.sv
// Scoreboard bench for metro_gate_ctrl: directed cycles push expected outputs,
// a negedge monitor pops and compares. A CNT_W=2 twin on the same inputs exercises counter wrap.
module tb_metro_gate_ctrl;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] GRNT = 2'b01;
    localparam logic [1:0] DENY = 2'b10;
    localparam logic [1:0] LOCK = 2'b11;

    typedef struct packed {
        logic [1:0]  st;
        logic        tg;
        logic [1:0]  fc;
        logic [15:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  access_code;
    logic        validate_code;
    logic        pass_sensor;

    logic        open_access_door, deny_led, lockout, tailgate_alarm;
    logic [1:0]  state_out, fail_count;
    logic [15:0] pass_count;

    logic        w_door, w_deny, w_lock, w_tg;
    logic [1:0]  w_state, w_fail, w_pass;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] exp_pass;
    int          n_vec = 0;
    int          n_err = 0;
    int          vec_idx = 0;

    always #5 clk = ~clk;

    metro_gate_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .access_code      (access_code),
        .validate_code    (validate_code),
        .pass_sensor      (pass_sensor),
        .open_access_door (open_access_door),
        .deny_led         (deny_led),
        .lockout          (lockout),
        .tailgate_alarm   (tailgate_alarm),
        .state_out        (state_out),
        .fail_count       (fail_count),
        .pass_count       (pass_count)
    );

    metro_gate_ctrl #(.CNT_W(2)) dut_w (
        .clk              (clk),
        .rst              (rst),
        .access_code      (access_code),
        .validate_code    (validate_code),
        .pass_sensor      (pass_sensor),
        .open_access_door (w_door),
        .deny_led         (w_deny),
        .lockout          (w_lock),
        .tailgate_alarm   (w_tg),
        .state_out        (w_state),
        .fail_count       (w_fail),
        .pass_count       (w_pass)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] pack_exp(input exp_t e);
        logic door, deny, lock;
        door = (e.st == GRNT);
        deny = (e.st == DENY);
        lock = (e.st == LOCK);
        return {28'd0, e.st, door, deny, lock, e.tg, e.fc, e.pc,
                e.st, door, deny, lock, e.tg, e.fc, e.pc[1:0]};
    endfunction

    function automatic logic [63:0] pack_act();
        return {28'd0, state_out, open_access_door, deny_led, lockout, tailgate_alarm, fail_count, pass_count,
                w_state, w_door, w_deny, w_lock, w_tg, w_fail, w_pass};
    endfunction

    // One clock: drive inputs, record what the outputs must be after this edge.
    task automatic cyc(input logic v, input logic [3:0] code, input logic ps,
                       input logic [1:0] st, input logic [1:0] fc, input logic tg);
        exp_t e;
        validate_code = v;
        access_code   = code;
        pass_sensor   = ps;
        @(posedge clk);
        e.st = st;
        e.tg = tg;
        e.fc = fc;
        e.pc = exp_pass;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic hold(input int n, input logic [1:0] st, input logic [1:0] fc);
        for (int k = 0; k < n; k++) cyc(1'b0, 4'd0, 1'b0, st, fc, 1'b0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check($sformatf("vec%0d", vec_idx), pack_act(), pack_exp(mon_e));
                vec_idx++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; validate_code = 1'b0; access_code = 4'd0; pass_sensor = 1'b0; exp_pass = 16'd0;

        // Held in reset, inputs toggling: everything stays zero.
        for (int i = 0; i < 6; i++) cyc(i[0], 4'(i + 3), i[1], IDLE, 2'd0, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 4'd0, 1'b0, IDLE, 2'd0, 1'b0);

        // Full open window with no passage; a request mid-window is ignored.
        cyc(1'b1, 4'd9, 1'b0, GRNT, 2'd0, 1'b0);
        hold(6, GRNT, 2'd0);
        cyc(1'b1, 4'd2, 1'b0, GRNT, 2'd0, 1'b0);
        hold(8, GRNT, 2'd0);
        cyc(1'b0, 4'd0, 1'b0, IDLE, 2'd0, 1'b0);

        // Passage on the final open cycle counts once, no alarm.
        cyc(1'b1, 4'd9, 1'b0, GRNT, 2'd0, 1'b0);
        hold(15, GRNT, 2'd0);
        exp_pass = 16'd1;
        cyc(1'b0, 4'd0, 1'b1, IDLE, 2'd0, 1'b0);
        cyc(1'b0, 4'd0, 1'b0, IDLE, 2'd0, 1'b0);

        // Passage on the 5th open cycle closes the door early.
        cyc(1'b1, 4'd9, 1'b0, GRNT, 2'd0, 1'b0);
        hold(4, GRNT, 2'd0);
        exp_pass = 16'd2;
        cyc(1'b0, 4'd0, 1'b1, IDLE, 2'd0, 1'b0);
        cyc(1'b0, 4'd0, 1'b0, IDLE, 2'd0, 1'b0);

        // Tailgate in IDLE: one pulse per sensor-high cycle, count unchanged.
        cyc(1'b0, 4'd0, 1'b1, IDLE, 2'd0, 1'b1);
        cyc(1'b0, 4'd0, 1'b1, IDLE, 2'd0, 1'b1);
        cyc(1'b0, 4'd0, 1'b0, IDLE, 2'd0, 1'b0);

        // Three rejects in a row: deny, deny, lockout.
        cyc(1'b1, 4'd2, 1'b0, DENY, 2'd1, 1'b0);
        cyc(1'b0, 4'd0, 1'b1, DENY, 2'd1, 1'b1);
        hold(2, DENY, 2'd1);
        cyc(1'b0, 4'd0, 1'b0, IDLE, 2'd1, 1'b0);
        cyc(1'b1, 4'd2, 1'b0, DENY, 2'd2, 1'b0);
        hold(3, DENY, 2'd2);
        cyc(1'b0, 4'd0, 1'b0, IDLE, 2'd2, 1'b0);
        cyc(1'b1, 4'd2, 1'b0, LOCK, 2'd3, 1'b0);
        hold(9, LOCK, 2'd3);
        cyc(1'b1, 4'd9, 1'b0, LOCK, 2'd3, 1'b0);
        cyc(1'b0, 4'd0, 1'b1, LOCK, 2'd3, 1'b1);
        hold(20, LOCK, 2'd3);
        cyc(1'b0, 4'd0, 1'b0, IDLE, 2'd0, 1'b0);

        // Range boundaries 3 / 4 / 11 / 12.
        cyc(1'b1, 4'd3, 1'b0, DENY, 2'd1, 1'b0);
        hold(3, DENY, 2'd1);
        cyc(1'b0, 4'd0, 1'b0, IDLE, 2'd1, 1'b0);
        cyc(1'b1, 4'd4, 1'b0, GRNT, 2'd0, 1'b0);
        exp_pass = 16'd3;
        cyc(1'b0, 4'd0, 1'b1, IDLE, 2'd0, 1'b0);
        cyc(1'b1, 4'd11, 1'b0, GRNT, 2'd0, 1'b0);
        exp_pass = 16'd4;
        cyc(1'b0, 4'd0, 1'b1, IDLE, 2'd0, 1'b0);
        cyc(1'b1, 4'd12, 1'b0, DENY, 2'd1, 1'b0);
        hold(3, DENY, 2'd1);
        cyc(1'b0, 4'd0, 1'b0, IDLE, 2'd1, 1'b0);

        // Two rejects, then a valid code clears the fail count.
        cyc(1'b1, 4'd0, 1'b0, DENY, 2'd2, 1'b0);
        hold(3, DENY, 2'd2);
        cyc(1'b0, 4'd0, 1'b0, IDLE, 2'd2, 1'b0);
        cyc(1'b1, 4'd4, 1'b0, GRNT, 2'd0, 1'b0);
        hold(2, GRNT, 2'd0);
        exp_pass = 16'd5;
        cyc(1'b0, 4'd0, 1'b1, IDLE, 2'd0, 1'b0);

        // Asynchronous reset mid-open: door drops before the next edge.
        cyc(1'b1, 4'd9, 1'b0, GRNT, 2'd0, 1'b0);
        hold(2, GRNT, 2'd0);
        #2 rst = 1'b0;
        #1;
        check("async_reset", {state_out, open_access_door, fail_count, pass_count, w_door},
              {IDLE, 1'b0, 2'd0, 16'd0, 1'b0});
        exp_pass = 16'd0;
        cyc(1'b1, 4'd9, 1'b0, IDLE, 2'd0, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 4'd11, 1'b0, GRNT, 2'd0, 1'b0);
        exp_pass = 16'd1;
        cyc(1'b0, 4'd0, 1'b1, IDLE, 2'd0, 1'b0);

        repeat (2) @(negedge clk);
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
